chip_io_divider: RTL and testbench

- Registered pad-ownership crossbar for a 2x2 multi-project chip.
- Up to four user macros each present north (10b), west (14b) and east (14b) output/output-enable buses.
- A 4-bit configuration word selects which macro drives the chip's west, east and north pad rings.
- Sits between the macro array and the pad frame; all pad outputs are registered.

---
 rtl/chip_io_divider.sv | 84 ++++++++
 tb/tb_chip_io_divider.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip_io_divider.sv
// chip_io_divider: registered pad-ownership crossbar steering n macros onto the west, east and north pad rings.
// Define CHIP_IO_DIVIDER_SAFE_SWITCH_EN to insert a one-cycle tri-state gap whenever configuration changes.
module chip_io_divider #(
    parameter int n = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  configuration,
    input  logic [9:0]  north_o  [n-1:0],
    input  logic [9:0]  north_oe [n-1:0],
    input  logic [13:0] west_o   [n-1:0],
    input  logic [13:0] west_oe  [n-1:0],
    input  logic [13:0] east_o   [n-1:0],
    input  logic [13:0] east_oe  [n-1:0],
    output logic [13:0] IO_west_o,
    output logic [13:0] IO_west_oe,
    output logic [13:0] IO_east_o,
    output logic [13:0] IO_east_oe,
    output logic [9:0]  IO_north_o,
    output logic [9:0]  IO_north_oe
);
    logic [1:0]  w, e;
    logic [13:0] w_o, w_oe, e_o, e_oe;
    logic [4:0]  nl_o, nl_oe, nh_o, nh_oe;
    logic        gap;

    assign w = configuration[1:0];
    assign e = configuration[3:2];

    // Scanning only existing macros keeps selects >= n at zero with no out-of-range access.
    always_comb begin
        w_o = '0;
        w_oe = '0;
        e_o = '0;
        e_oe = '0;
        nl_o = '0;
        nl_oe = '0;
        nh_o = '0;
        nh_oe = '0;
        for (int k = 0; k < n; k++) begin
            if (int'(w) == k) begin
                w_o = west_o[k];
                w_oe = west_oe[k];
                nl_o = north_o[k][4:0];
                nl_oe = north_oe[k][4:0];
            end
            if (int'(e) == k) begin
                e_o = east_o[k];
                e_oe = east_oe[k];
                nh_o = north_o[k][9:5];
                nh_oe = north_oe[k][9:5];
            end
        end
    end

`ifdef CHIP_IO_DIVIDER_SAFE_SWITCH_EN
    logic [3:0] cfg_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cfg_q <= '0;
        else cfg_q <= configuration;
    end
    assign gap = configuration != cfg_q;
`else
    assign gap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst || gap) begin
            IO_west_o <= '0;
            IO_west_oe <= '0;
            IO_east_o <= '0;
            IO_east_oe <= '0;
            IO_north_o <= '0;
            IO_north_oe <= '0;
        end else begin
            IO_west_o <= w_o;
            IO_west_oe <= w_oe;
            IO_east_o <= e_o;
            IO_east_oe <= e_oe;
            IO_north_o <= {nh_o, nl_o};
            IO_north_oe <= {nh_oe, nl_oe};
        end
    end
endmodule

// File: tb/tb_chip_io_divider.sv
// tb_chip_io_divider: scoreboard and vector-table bench for 4-macro and 2-macro crossbar instances.
module tb_chip_io_divider;
    typedef struct packed {
        logic [13:0] wo, woe, eo, eoe;
        logic [9:0]  no, noe;
    } exp_t;

    typedef struct {
        logic [3:0] cfg;
        exp_t       e4;
        exp_t       e2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  configuration = '0;
    logic [9:0]  mn_o [3:0], mn_oe [3:0];
    logic [13:0] mw_o [3:0], mw_oe [3:0], me_o [3:0], me_oe [3:0];
    logic [9:0]  n2_o [1:0], n2_oe [1:0];
    logic [13:0] w2_o [1:0], w2_oe [1:0], e2_o [1:0], e2_oe [1:0];
    exp_t        a4, a2;
    exp_t        q4 [$], q2 [$];
    logic [3:0]  copy = '0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            n2_o[i] = mn_o[i];
            n2_oe[i] = mn_oe[i];
            w2_o[i] = mw_o[i];
            w2_oe[i] = mw_oe[i];
            e2_o[i] = me_o[i];
            e2_oe[i] = me_oe[i];
        end
    end

    chip_io_divider #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .configuration(configuration),
        .north_o(mn_o), .north_oe(mn_oe), .west_o(mw_o), .west_oe(mw_oe),
        .east_o(me_o), .east_oe(me_oe),
        .IO_west_o(a4.wo), .IO_west_oe(a4.woe), .IO_east_o(a4.eo), .IO_east_oe(a4.eoe),
        .IO_north_o(a4.no), .IO_north_oe(a4.noe)
    );

    chip_io_divider #(.n(2)) dut2 (
        .clk(clk), .rst(rst), .configuration(configuration),
        .north_o(n2_o), .north_oe(n2_oe), .west_o(w2_o), .west_oe(w2_oe),
        .east_o(e2_o), .east_oe(e2_oe),
        .IO_west_o(a2.wo), .IO_west_oe(a2.woe), .IO_east_o(a2.eo), .IO_east_oe(a2.eoe),
        .IO_north_o(a2.no), .IO_north_oe(a2.noe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t act, input exp_t req);
        chk({tag, ".west_o"}, 32'(act.wo), 32'(req.wo));
        chk({tag, ".west_oe"}, 32'(act.woe), 32'(req.woe));
        chk({tag, ".east_o"}, 32'(act.eo), 32'(req.eo));
        chk({tag, ".east_oe"}, 32'(act.eoe), 32'(req.eoe));
        chk({tag, ".north_o"}, 32'(act.no), 32'(req.no));
        chk({tag, ".north_oe"}, 32'(act.noe), 32'(req.noe));
    endtask

    // North ring is merged from two masked halves: low half follows west owner, high half east owner.
    function automatic exp_t model(input int nn, input logic [3:0] c, input bit g);
        exp_t r = '0;
        int wi = int'(c[1:0]);
        int ei = int'(c[3:2]);
        if (!g && wi < nn) begin
            r.wo = mw_o[wi];
            r.woe = mw_oe[wi];
            r.no = r.no | (mn_o[wi] & 10'h01F);
            r.noe = r.noe | (mn_oe[wi] & 10'h01F);
        end
        if (!g && ei < nn) begin
            r.eo = me_o[ei];
            r.eoe = me_oe[ei];
            r.no = r.no | (mn_o[ei] & 10'h3E0);
            r.noe = r.noe | (mn_oe[ei] & 10'h3E0);
        end
        return r;
    endfunction

    task automatic tick();
        bit g = 1'b0;
`ifdef CHIP_IO_DIVIDER_SAFE_SWITCH_EN
        g = configuration != copy;
        copy = configuration;
`endif
        q4.push_back(model(4, configuration, g));
        q2.push_back(model(2, configuration, g));
        @(posedge clk);
        #1;
        chk_all("sb4", a4, q4.pop_front());
        chk_all("sb2", a2, q2.pop_front());
    endtask

    task automatic sweep_data();
        for (int k = 0; k < 4; k++) begin
            mw_o[k] = 14'h1000 + 14'(k);
            me_o[k] = 14'h2000 + 14'(k);
            mn_o[k] = 10'h3C0 + 10'(k);
            mw_oe[k] = '1;
            me_oe[k] = '1;
            mn_oe[k] = '1;
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 4; k++) begin
            mw_o[k] = 14'($urandom);
            me_o[k] = 14'($urandom);
            mn_o[k] = 10'($urandom);
            mw_oe[k] = 14'($urandom);
            me_oe[k] = 14'($urandom);
            mn_oe[k] = 10'($urandom);
        end
    endtask

    localparam exp_t ALL0 = '0;

    initial begin
        vec_t vt [6];
        vt[0] = '{4'b1001, '{14'h1001, 14'h3FFF, 14'h2002, 14'h3FFF, 10'h3C1, 10'h3FF},
                           '{14'h1001, 14'h3FFF, 14'h0000, 14'h0000, 10'h001, 10'h01F}};
        vt[1] = '{4'b1111, '{14'h1003, 14'h3FFF, 14'h2003, 14'h3FFF, 10'h3C3, 10'h3FF}, ALL0};
        vt[2] = '{4'b0000, '{14'h1000, 14'h3FFF, 14'h2000, 14'h3FFF, 10'h3C0, 10'h3FF},
                           '{14'h1000, 14'h3FFF, 14'h2000, 14'h3FFF, 10'h3C0, 10'h3FF}};
        vt[3] = '{4'b0110, '{14'h1002, 14'h3FFF, 14'h2001, 14'h3FFF, 10'h3C2, 10'h3FF},
                           '{14'h0000, 14'h0000, 14'h2001, 14'h3FFF, 10'h3C0, 10'h3E0}};
        vt[4] = '{4'b1110, '{14'h1002, 14'h3FFF, 14'h2003, 14'h3FFF, 10'h3C2, 10'h3FF}, ALL0};
        vt[5] = '{4'b0100, '{14'h1000, 14'h3FFF, 14'h2001, 14'h3FFF, 10'h3C0, 10'h3FF},
                           '{14'h1000, 14'h3FFF, 14'h2001, 14'h3FFF, 10'h3C0, 10'h3FF}};

        rand_data();
        configuration = 4'($urandom);
        #1;
        chk_all("rst4", a4, ALL0);
        chk_all("rst2", a2, ALL0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("rst4_held", a4, ALL0);
        @(negedge clk);
        rst = 1'b0;
        copy = '0;
        repeat (20) begin
            tick();
            configuration = 4'($urandom);
        end

        // Mid-cycle asynchronous reset assertion.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("arst4", a4, ALL0);
        chk_all("arst2", a2, ALL0);
        @(negedge clk);
        rst = 1'b0;
        copy = '0;

        sweep_data();
        for (int c = 0; c < 16; c++) begin
            configuration = 4'(c);
            repeat (10) tick();
        end

        foreach (vt[i]) begin
            configuration = vt[i].cfg;
            tick();
            tick();
            chk_all($sformatf("vec%0d_n4", i), a4, vt[i].e4);
            chk_all($sformatf("vec%0d_n2", i), a2, vt[i].e2);
        end

        // Latency: one edge from a bus change to the pads, no combinational path.
        configuration = 4'b0000;
        mw_o[0] = 14'h0000;
        tick();
        tick();
        mw_o[0] = 14'h3FFF;
        #1;
        chk("lat_before_edge", 32'(a4.wo), 32'h0000);
        tick();
        chk("lat_after_edge", 32'(a4.wo), 32'h3FFF);

        sweep_data();
        configuration = 4'b0000;
        tick();
        tick();
        configuration = 4'b0101;
        tick();
`ifdef CHIP_IO_DIVIDER_SAFE_SWITCH_EN
        chk_all("gap4", a4, ALL0);
        tick();
`endif
        chk("sw_west", 32'(a4.wo), 32'h1001);
        chk("sw_east", 32'(a4.eo), 32'h2001);
        chk("sw_north", 32'(a4.no), 32'h3C1);

        for (int i = 0; i < 300; i++) begin
            rand_data();
            if ($urandom_range(0, 2) == 0) configuration = 4'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
